// File: rtl/fetch_burst_unit.sv
// Instruction fetch front end: issues AXI4 INCR read bursts that never cross a 4 KB page
// and buffers the returned words with their PCs in a FIFO feeding decode.
module fetch_burst_unit #(
    parameter int unsigned BURST_LEN    = 4,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter logic [31:0] RESET_VECTOR = 32'h8000_0000,
    parameter logic [3:0]  AXI_ID       = 4'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_i,
    input  logic [31:0] dnpc_i,
    output logic        valid_post_o,
    input  logic        ready_post_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        arvalid_o,
    input  logic        arready_i,
    output logic [31:0] araddr_o,
    output logic [3:0]  arid_o,
    output logic [7:0]  arlen_o,
    output logic [2:0]  arsize_o,
    output logic [1:0]  arburst_o,
    input  logic        rvalid_i,
    output logic        rready_o,
    input  logic [31:0] rdata_i,
    input  logic [1:0]  rresp_i,
    input  logic        rlast_i,
    input  logic [3:0]  rid_i,
    output logic        awvalid_o,
    output logic [31:0] awaddr_o,
    output logic [3:0]  awid_o,
    output logic [7:0]  awlen_o,
    output logic [2:0]  awsize_o,
    output logic [1:0]  awburst_o,
    output logic        wvalid_o,
    output logic [31:0] wdata_o,
    output logic [3:0]  wstrb_o,
    output logic        wlast_o,
    output logic        bready_o,
    output logic        err_o,
    output logic [31:0] perf_beats_o,
    output logic [31:0] perf_stall_o
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, AR, R, DRAIN} state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    state_e       state_q, state_d;
    logic [31:0]  fetch_addr_q, fetch_addr_d;
    logic         ar_flushed_q, ar_flushed_d;
    logic         arvalid_q, arvalid_d;
    logic [31:0]  araddr_q, araddr_d;
    logic [7:0]   arlen_q, arlen_d;
    logic         rready_q, rready_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic         valid_q, valid_d;
    logic         err_q, err_d;
    logic [31:0]  perf_beats_q, perf_beats_d, perf_stall_q, perf_stall_d;
    fetch_entry_t mem_q [FIFO_DEPTH];

    logic         beat, enq, deq, space_ok;
    logic [10:0]  words_left, burst_beats;
    logic         unused_rid;

    assign unused_rid  = ^rid_i;
    assign space_ok    = count_q <= CW'(FIFO_DEPTH - BURST_LEN);
    // Words remaining before the next 4 KB page boundary caps the burst.
    assign words_left  = 11'd1024 - 11'(fetch_addr_q[11:2]);
    assign burst_beats = (words_left < 11'(BURST_LEN)) ? words_left : 11'(BURST_LEN);

    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        ar_flushed_d = 1'b0;
        enq          = 1'b0;
        beat         = rvalid_i && rready_q;

        case (state_q)
            IDLE: if (!redirect_i && space_ok) state_d = AR;
            AR: begin
                if (arready_i) state_d = (redirect_i || ar_flushed_q) ? DRAIN : R;
                else           ar_flushed_d = ar_flushed_q || redirect_i;
            end
            R: begin
                if (beat) begin
                    enq          = !redirect_i;
                    fetch_addr_d = fetch_addr_q + 32'd4;
                    if (rlast_i) state_d = IDLE;
                end
                if (redirect_i && !(beat && rlast_i)) state_d = DRAIN;
            end
            DRAIN: if (beat && rlast_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (redirect_i) fetch_addr_d = dnpc_i;

        arvalid_d = (state_d == AR);
        araddr_d  = '0;
        arlen_d   = '0;
        if (state_d == AR) begin
            araddr_d = (state_q == AR) ? araddr_q : fetch_addr_q;
            arlen_d  = (state_q == AR) ? arlen_q  : 8'(burst_beats - 11'd1);
        end
        rready_d = (state_d == R) || (state_d == DRAIN);

        // Redirect flushes the buffer and swallows this cycle's dequeue and beat.
        deq      = valid_q && ready_post_i && !redirect_i;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (redirect_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq) wr_ptr_d = wr_ptr_q + PW'(1);
            if (deq) rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(enq) - CW'(deq);
        end
        valid_d = (count_d != '0);

        err_d        = err_q || (beat && (rresp_i != 2'b00));
        perf_beats_d = perf_beats_q + 32'(beat);
        perf_stall_d = perf_stall_q + 32'(state_q != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            fetch_addr_q <= RESET_VECTOR;
            ar_flushed_q <= 1'b0;
            arvalid_q    <= 1'b0;
            araddr_q     <= '0;
            arlen_q      <= '0;
            rready_q     <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            valid_q      <= 1'b0;
            err_q        <= 1'b0;
            perf_beats_q <= '0;
            perf_stall_q <= '0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            ar_flushed_q <= ar_flushed_d;
            arvalid_q    <= arvalid_d;
            araddr_q     <= araddr_d;
            arlen_q      <= arlen_d;
            rready_q     <= rready_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            valid_q      <= valid_d;
            err_q        <= err_d;
            perf_beats_q <= perf_beats_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    // Buffer storage; occupancy is tracked by count_q so entries need no reset.
    always_ff @(posedge clk) begin
        if (enq) mem_q[wr_ptr_q] <= fetch_entry_t'{pc: fetch_addr_q, inst: rdata_i};
    end

    assign valid_post_o = valid_q;
    assign pc_o         = valid_q ? mem_q[rd_ptr_q].pc   : '0;
    assign inst_o       = valid_q ? mem_q[rd_ptr_q].inst : '0;
    assign arvalid_o    = arvalid_q;
    assign araddr_o     = araddr_q;
    assign arlen_o      = arlen_q;
    assign arid_o       = arvalid_q ? AXI_ID : 4'h0;
    assign arsize_o     = arvalid_q ? 3'b010 : 3'b000;
    assign arburst_o    = arvalid_q ? 2'b01  : 2'b00;
    assign rready_o     = rready_q;
    assign err_o        = err_q;
    assign perf_beats_o = perf_beats_q;
    assign perf_stall_o = perf_stall_q;

    assign awvalid_o = 1'b0;
    assign awaddr_o  = '0;
    assign awid_o    = '0;
    assign awlen_o   = '0;
    assign awsize_o  = '0;
    assign awburst_o = '0;
    assign wvalid_o  = 1'b0;
    assign wdata_o   = '0;
    assign wstrb_o   = '0;
    assign wlast_o   = 1'b0;
    assign bready_o  = 1'b0;

endmodule
